vio_start_src: RTL and testbench
================================

# vio_start_src

Synthesizable stand-in for the debug start-probe source that drives the `start` input of the UART master test sequencer. It produces a single registered control level, `probe_out0`. A downstream two-flop rising-edge detector consumes that level and launches one transmit sequence. The level is driven by a direct level write, a one-shot pulse request, or an optional periodic auto-trigger.

## Interface
Parameters:
- INIT_VALUE, 1'b0, level of probe_out0 while reset is asserted and after reset.
- PULSE_WIDTH, 4, number of cycles a pulse holds probe_out0 high. Also the minimum low gap after each pulse. Legal values are ≥2.
- AUTO_PERIOD, 1000, number of idle cycles between auto-triggered pulses. Legal values are ≥1.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock; all state is updated on the rising edge.
- reset_i  input  1  asynchronous reset, active-high.
- set_i  input  1  level-write strobe.
- set_val_i  input  1  level written to probe_out0 when set_i is high.
- pulse_i  input  1  one-shot pulse request.
- auto_en_i  input  1  enables the periodic auto-trigger.
- probe_out0  output  1  start level seen by the consumer's edge detector.
- busy_o  output  1  high while the FSM is in PULSE or GAP.

## Operation
- The FSM has three states: IDLE, PULSE, GAP. It uses a width counter sized for PULSE_WIDTH and an auto counter sized for AUTO_PERIOD.
- Request priority, highest first: set_i, then pulse_i, then auto-trigger.
- set_i = 1, in any state:
  - probe_out0 ← set_val_i.
  - FSM → IDLE; width and auto counters → 0.
  - Any pulse in flight is cancelled, and any pulse_i sampled in the same cycle is dropped.
- IDLE with pulse_i = 1 and probe_out0 = 0:
  - probe_out0 ← 1, width counter ← 0, FSM → PULSE.
- IDLE with pulse_i = 1 and probe_out0 = 1: the request is ignored, because no rising edge is possible.
- PULSE:
  - Each cycle the width counter increments.
  - When it reaches PULSE_WIDTH-1: probe_out0 ← 0, counter ← 0, FSM → GAP.
- GAP:
  - probe_out0 is held at 0.
  - When the counter reaches PULSE_WIDTH-1, FSM → IDLE.
  - pulse_i is ignored.
- pulse_i in PULSE or GAP is dropped, never queued.
- Auto-trigger:
  - In IDLE with auto_en_i = 1 and probe_out0 = 0, the auto counter increments each cycle.
  - When it reaches AUTO_PERIOD-1, a pulse starts exactly as a pulse_i request would, and the counter clears.
  - The auto counter holds at 0 whenever auto_en_i = 0, the FSM is outside IDLE, or probe_out0 = 1.
  - An explicit pulse_i in IDLE also clears the auto counter.
- busy_o = 1 exactly when the FSM is in PULSE or GAP. It is registered together with the state.

## Timing
- Reset: probe_out0 = INIT_VALUE, busy_o = 0, FSM = IDLE, all counters 0.
  - Asserting reset_i mid-pulse returns the outputs to these values immediately, without waiting for a clock edge.
  - The first state update is on the first rising clk edge after reset_i deasserts.
- Outputs are registered; there is no combinational input-to-output path.
- pulse_i sampled high at edge N:
  - probe_out0 is high from edge N through edge N+PULSE_WIDTH-1, i.e. exactly PULSE_WIDTH cycles.
  - probe_out0 is low for at least PULSE_WIDTH cycles afterwards.
  - busy_o clears at edge N+2·PULSE_WIDTH.
- set_i sampled at edge N: probe_out0 = set_val_i after edge N, i.e. one-cycle latency.
- With auto_en_i held high from reset and no other stimulus, the rising edges of probe_out0 are spaced by 2·PULSE_WIDTH + AUTO_PERIOD cycles. The first rising edge appears AUTO_PERIOD cycles after reset deassertion.
- Minimum high and low widths of PULSE_WIDTH (≥2) guarantee that a two-flop synchronizer plus edge detector sees exactly one rising edge per pulse.

## Test plan
- Reset check: hold reset_i, then release → probe_out0 = INIT_VALUE (0), busy_o = 0. Re-assert reset_i asynchronously mid-pulse → probe_out0 drops to 0 before the next clock edge.
- Single pulse, PULSE_WIDTH = 4: one-cycle pulse_i → probe_out0 high for exactly 4 cycles, then low; busy_o high for 8 cycles; the consumer's edge detector fires once.
- Dropped request: pulse_i during PULSE and again during GAP → no extra high period; total high time is 4 cycles.
- Level write: set_i = 1 with set_val_i = 1 in the middle of a pulse → probe_out0 stays 1, busy_o = 0 next cycle. A following pulse_i is ignored. Then set_i = 1 with set_val_i = 0 → probe_out0 = 0.
- Auto mode, AUTO_PERIOD = 10, PULSE_WIDTH = 4: auto_en_i = 1 → first rising edge 10 cycles after reset release, then rising edges every 18 cycles. Dropping auto_en_i stops pulses, and the period restarts from 0 when auto_en_i is raised again.
- Simultaneous set_i and pulse_i in IDLE with set_val_i = 0 → probe_out0 stays 0 and no pulse starts.

Source files
------------

// File: rtl/vio_start_src.sv
// vio_start_src
// Synthesizable stand-in for the debug start-probe source that feeds the
// UART master test sequencer's `start` input. It drives one registered level,
// probe_out0, from one of three sources, highest priority first:
//   - a direct level write (set_i / set_val_i)
//   - a one-shot pulse request (pulse_i)
//   - an optional periodic auto-trigger (auto_en_i)
// Every pulse is high for PULSE_WIDTH cycles and is followed by a low gap of
// PULSE_WIDTH cycles. This lets a two-flop synchronizer plus edge detector see
// exactly one rising edge per pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_i    in   asynchronous reset, active-high
//   set_i      in   level-write strobe
//   set_val_i  in   level written to probe_out0 when set_i is high
//   pulse_i    in   one-shot pulse request
//   auto_en_i  in   enables the periodic auto-trigger
//   probe_out0 out  registered start level
//   busy_o     out  registered, high while a pulse or its gap is in progress
module vio_start_src #(
    parameter logic        INIT_VALUE  = 1'b0,
    parameter int unsigned PULSE_WIDTH = 4,
    parameter int unsigned AUTO_PERIOD = 1000
) (
    input  logic clk,
    input  logic reset_i,
    input  logic set_i,
    input  logic set_val_i,
    input  logic pulse_i,
    input  logic auto_en_i,
    output logic probe_out0,
    output logic busy_o
);

    localparam int unsigned WCNT_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int unsigned ACNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [ACNT_W-1:0]   r_acnt;
    logic                r_probe;
    logic                r_busy;

    logic                w_wcnt_last;
    logic                w_auto_fire;
    logic                w_start;

    assign w_wcnt_last = (r_wcnt == WCNT_W'(PULSE_WIDTH - 1));
    // Auto counter only advances while enabled, idle and low, so reaching the
    // terminal count implies all of those conditions still hold.
    assign w_auto_fire = auto_en_i && (r_acnt == ACNT_W'(AUTO_PERIOD - 1));
    // A pulse can only start from a low level; otherwise no rising edge results.
    assign w_start     = !r_probe && (pulse_i || w_auto_fire);

    // Single-process FSM with registered outputs.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_acnt  <= '0;
            r_probe <= INIT_VALUE;
            r_busy  <= 1'b0;
        end else if (set_i) begin
            // Level write wins over everything and cancels any pulse in flight.
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_acnt  <= '0;
            r_probe <= set_val_i;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_PULSE;
                        r_wcnt  <= '0;
                        r_acnt  <= '0;
                        r_probe <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (auto_en_i && !r_probe) begin
                        r_acnt  <= r_acnt + ACNT_W'(1);
                    end else begin
                        r_acnt  <= '0;
                    end
                end
                ST_PULSE: begin
                    r_acnt <= '0;
                    if (w_wcnt_last) begin
                        r_state <= ST_GAP;
                        r_wcnt  <= '0;
                        r_probe <= 1'b0;
                    end else begin
                        r_wcnt  <= r_wcnt + WCNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // Hold low for the minimum gap; requests here are dropped.
                    r_acnt  <= '0;
                    r_probe <= 1'b0;
                    if (w_wcnt_last) begin
                        r_state <= ST_IDLE;
                        r_wcnt  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wcnt  <= r_wcnt + WCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wcnt  <= '0;
                    r_acnt  <= '0;
                    r_probe <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign probe_out0 = r_probe;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_vio_start_src.sv
// Testbench for vio_start_src (PULSE_WIDTH=4, AUTO_PERIOD=10).
// Stimulus pushes expected output transitions {cycle, probe, busy} into a
// scoreboard queue; a monitor pops one entry per observed transition.
module tb_vio_start_src;

    localparam int unsigned PW = 4;
    localparam int unsigned AP = 10;

    logic clk       = 1'b0;
    logic reset_i   = 1'b1;
    logic set_i     = 1'b0;
    logic set_val_i = 1'b0;
    logic pulse_i   = 1'b0;
    logic auto_en_i = 1'b0;
    logic probe_out0;
    logic busy_o;

    vio_start_src #(
        .INIT_VALUE  (1'b0),
        .PULSE_WIDTH (PW),
        .AUTO_PERIOD (AP)
    ) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .set_i      (set_i),
        .set_val_i  (set_val_i),
        .pulse_i    (pulse_i),
        .auto_en_i  (auto_en_i),
        .probe_out0 (probe_out0),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic probe;
        logic busy;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;

    // Edge index since reset release: after edge k, cyc == k.
    always @(posedge clk or posedge reset_i) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Consumer model: two-flop synchronizer plus rising-edge detector.
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   ed_count = 0;
    always @(posedge clk) begin
        s1 <= probe_out0;
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) ed_count <= ed_count + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each change of {probe_out0, busy_o} must match the next expectation.
    logic prev_probe = 1'b0;
    logic prev_busy  = 1'b0;
    always @(negedge clk) begin
        if (!reset_i && (probe_out0 != prev_probe || busy_o != prev_busy)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got probe=%0b busy=%0b at cyc %0d expected none",
                         probe_out0, busy_o, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.probe != probe_out0 || e.busy != busy_o) begin
                    n_err++;
                    $display("FAIL event: got cyc=%0d probe=%0b busy=%0b expected cyc=%0d probe=%0b busy=%0b",
                             cyc, probe_out0, busy_o, e.cyc, e.probe, e.busy);
                end
            end
        end
        prev_probe = probe_out0;
        prev_busy  = busy_o;
    end

    task automatic push_ev(input int c, input logic p, input logic b);
        ev_t e;
        e.cyc   = c;
        e.probe = p;
        e.busy  = b;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
        check("wait_cyc_timeout", int'(cyc >= target), 1);
    endtask

    // Drive a one-cycle pulse_i request; the sampling edge is returned.
    task automatic do_pulse(output int n);
        n = cyc + 1;
        pulse_i = 1'b1;
        @(negedge clk);
        pulse_i = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int base;

        // Reset state, held and after release.
        tick(3);
        check("reset_probe_held", int'(probe_out0), 0);
        check("reset_busy_held", int'(busy_o), 0);
        reset_i = 1'b0;
        tick(2);
        check("reset_probe_after", int'(probe_out0), 0);
        check("reset_busy_after", int'(busy_o), 0);

        // Single pulse: high PW cycles, busy 2*PW cycles, one detected edge.
        base = ed_count;
        push_ev(cyc + 1, 1'b1, 1'b1);
        push_ev(cyc + 1 + PW, 1'b0, 1'b1);
        push_ev(cyc + 1 + 2 * PW, 1'b0, 1'b0);
        do_pulse(n);
        wait_cyc(n + 2 * PW + 4);
        check("single_sb_empty", sb.size(), 0);
        check("single_edges", ed_count - base, 1);

        // Requests during PULSE and GAP are dropped.
        base = ed_count;
        push_ev(cyc + 1, 1'b1, 1'b1);
        push_ev(cyc + 1 + PW, 1'b0, 1'b1);
        push_ev(cyc + 1 + 2 * PW, 1'b0, 1'b0);
        do_pulse(n);
        tick(1);
        do_pulse(k);
        check("drop_in_pulse_state", int'(busy_o && probe_out0), 1);
        tick(2);
        do_pulse(k);
        wait_cyc(n + 2 * PW + 4);
        check("drop_sb_empty", sb.size(), 0);
        check("drop_edges", ed_count - base, 1);

        // Level write high mid-pulse, ignored pulse, then level write low.
        base = ed_count;
        push_ev(cyc + 1, 1'b1, 1'b1);
        do_pulse(n);
        tick(1);
        push_ev(cyc + 1, 1'b1, 1'b0);
        set_i = 1'b1; set_val_i = 1'b1;
        @(negedge clk);
        set_i = 1'b0; set_val_i = 1'b0;
        check("set1_probe", int'(probe_out0), 1);
        check("set1_busy", int'(busy_o), 0);
        do_pulse(k);
        tick(6);
        check("set1_pulse_ignored_busy", int'(busy_o), 0);
        push_ev(cyc + 1, 1'b0, 1'b0);
        set_i = 1'b1; set_val_i = 1'b0;
        @(negedge clk);
        set_i = 1'b0;
        tick(4);
        check("set0_probe", int'(probe_out0), 0);
        check("set_sb_empty", sb.size(), 0);
        check("set_edges", ed_count - base, 1);

        // Simultaneous set_i (value 0) and pulse_i in IDLE: no pulse.
        base = ed_count;
        set_i = 1'b1; set_val_i = 1'b0; pulse_i = 1'b1;
        @(negedge clk);
        set_i = 1'b0; pulse_i = 1'b0;
        check("simul_busy_next", int'(busy_o), 0);
        tick(10);
        check("simul_probe", int'(probe_out0), 0);
        check("simul_busy", int'(busy_o), 0);
        check("simul_edges", ed_count - base, 0);

        // Asynchronous reset mid-pulse clears outputs before the next edge.
        push_ev(cyc + 1, 1'b1, 1'b1);
        do_pulse(n);
        tick(1);
        sb.delete();
        #1 reset_i = 1'b1;
        #1;
        check("async_reset_probe", int'(probe_out0), 0);
        check("async_reset_busy", int'(busy_o), 0);

        // Auto mode with auto_en_i held from reset.
        auto_en_i = 1'b1;
        tick(4);
        base = ed_count;
        reset_i = 1'b0;
        push_ev(AP, 1'b1, 1'b1);
        push_ev(AP + PW, 1'b0, 1'b1);
        push_ev(AP + 2 * PW, 1'b0, 1'b0);
        push_ev(AP + (2 * PW + AP), 1'b1, 1'b1);
        push_ev(AP + (2 * PW + AP) + PW, 1'b0, 1'b1);
        push_ev(AP + (2 * PW + AP) + 2 * PW, 1'b0, 1'b0);
        wait_cyc(40);
        auto_en_i = 1'b0;
        wait_cyc(60);
        check("auto_off_probe", int'(probe_out0), 0);
        check("auto_off_sb_empty", sb.size(), 0);
        auto_en_i = 1'b1;
        push_ev(60 + AP, 1'b1, 1'b1);
        push_ev(60 + AP + PW, 1'b0, 1'b1);
        push_ev(60 + AP + 2 * PW, 1'b0, 1'b0);
        wait_cyc(80);
        auto_en_i = 1'b0;
        wait_cyc(100);
        check("auto_sb_empty", sb.size(), 0);
        check("auto_edges", ed_count - base, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
